// File: rtl/mem_responder.sv
// Memory-side responder: boot-loadable ROM, data RAM, wait-state FSM, read/write handshakes.
// Optional MEM_PARITY_EN adds an even-parity bit per RAM word with par_err reporting.
module mem_responder #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ena_i,
  input  logic              rom_read_i,
  input  logic              ram_ena_i,
  input  logic              ram_read_i,
  input  logic              ram_write_i,
  input  logic              ad_sel_i,
  input  logic [ADDR_W-1:0] pc_addr_i,
  input  logic [ADDR_W-1:0] op_addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              ld_en_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic              err_clr_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o,
  output logic              wack_o,
  output logic              busy_o,
  output logic              err_o,
  output logic              par_err_o
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef MEM_PARITY_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {K_NONE, K_WR, K_RD, K_RO} kind_t;

  logic [DATA_W-1:0] rom_q [DEPTH];
  logic [RAM_W-1:0]  ram_q [DEPTH];

  state_t            state_q;
  logic [3:0]        cnt_q;
  kind_t             kind_q, last_kind_q;
  logic [ADDR_W-1:0] addr_q, last_addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              last_vld_q;
  logic              wr_prev_q, rd_prev_q, ro_prev_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q, wack_q, busy_q, err_q, par_err_q;

  logic              wr_lvl, rd_lvl, ro_lvl;
  logic [ADDR_W-1:0] req_addr;
  kind_t             req_kind;
  logic              req_fire, proto_err, par_bad, err_set, resp_wr;
  logic [DATA_W-1:0] rom_rd;
  logic [RAM_W-1:0]  ram_rd, ram_wr_word;

  assign wr_lvl   = ram_ena_i & ram_write_i;
  assign rd_lvl   = ram_ena_i & ram_read_i;
  assign ro_lvl   = rom_ena_i & rom_read_i;
  assign req_addr = ad_sel_i ? op_addr_i : pc_addr_i;

  // Reads re-trigger on a new address or kind even while the strobe stays high.
  always_comb begin
    req_kind = K_NONE;
    req_fire = 1'b0;
    if (wr_lvl) begin
      req_kind = K_WR;
      req_fire = !wr_prev_q;
    end else if (rd_lvl) begin
      req_kind = K_RD;
      req_fire = !rd_prev_q || !last_vld_q || (req_addr != last_addr_q) || (last_kind_q != K_RD);
    end else if (ro_lvl) begin
      req_kind = K_RO;
      req_fire = !ro_prev_q || !last_vld_q || (req_addr != last_addr_q) || (last_kind_q != K_RO);
    end
  end

  assign proto_err = (wr_lvl & rd_lvl) | (wr_lvl & ro_lvl) | (rd_lvl & ro_lvl)
                   | (rom_ena_i & ram_ena_i) | (ram_read_i & ram_write_i);

  // A boot-load landing on the in-flight ROM address must win over the stale array word.
  assign rom_rd = (ld_en_i && ld_addr_i == addr_q) ? ld_data_i : rom_q[addr_q];
  assign ram_rd = ram_q[addr_q];

`ifdef MEM_PARITY_EN
  assign ram_wr_word = {^wdata_q, wdata_q};
  assign par_bad     = ram_rd[DATA_W] != ^ram_rd[DATA_W-1:0];
`else
  assign ram_wr_word = wdata_q;
  assign par_bad     = 1'b0;
`endif

  assign resp_wr = (state_q == RESP) && (kind_q == K_WR);
  assign err_set = ((state_q == IDLE) && req_fire && proto_err)
                 | ((state_q == RESP) && (kind_q == K_RD) && par_bad);

  // Arrays are never reset; a reset in RESP still blocks the RAM commit.
  always_ff @(posedge clk) begin
    if (ld_en_i) rom_q[ld_addr_i] <= ld_data_i;
    if (!rst && resp_wr) ram_q[addr_q] <= ram_wr_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      kind_q      <= K_NONE;
      last_kind_q <= K_NONE;
      addr_q      <= '0;
      last_addr_q <= '0;
      wdata_q     <= '0;
      last_vld_q  <= 1'b0;
      wr_prev_q   <= 1'b0;
      rd_prev_q   <= 1'b0;
      ro_prev_q   <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      wack_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      par_err_q   <= 1'b0;
    end else begin
      rvalid_q  <= 1'b0;
      wack_q    <= 1'b0;
      par_err_q <= 1'b0;
      wr_prev_q <= wr_lvl;
      rd_prev_q <= rd_lvl;
      ro_prev_q <= ro_lvl;
      err_q     <= err_set | (err_q & ~err_clr_i);
      case (state_q)
        IDLE: if (req_fire) begin
          addr_q      <= req_addr;
          kind_q      <= req_kind;
          wdata_q     <= wdata_i;
          last_addr_q <= req_addr;
          last_kind_q <= req_kind;
          last_vld_q  <= 1'b1;
          busy_q      <= 1'b1;
          cnt_q       <= CNT_INIT;
          state_q     <= (WAIT_STATES > 0) ? WAIT : RESP;
        end
        WAIT: begin
          if (cnt_q == 4'd0) state_q <= RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (kind_q == K_WR) begin
            wack_q <= 1'b1;
          end else begin
            rdata_q   <= (kind_q == K_RO) ? rom_rd : ram_rd[DATA_W-1:0];
            rvalid_q  <= 1'b1;
            par_err_q <= (kind_q == K_RD) && par_bad;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdata_o   = rdata_q;
  assign rvalid_o  = rvalid_q;
  assign wack_o    = wack_q;
  assign busy_o    = busy_q;
  assign err_o     = err_q;
  assign par_err_o = par_err_q;

endmodule
